// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the round-robin memory arbiter slice.
package mem_arb_pkg;

    localparam int NREQ_DEF   = 2;
    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_regfile.sv
// Small register-file memory: async clear, synchronous write, registered read.
module mem_regfile
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_2,
    input  logic              reset_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DATA_W-1:0]            rdata_q;

    // rdata_q only moves on a read, so it holds the last read value across writes.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            mem_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (we) mem_q[addr] <= wdata;
            if (re) rdata_q     <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter owning a small memory; one fixed 3-cycle op in flight
// (IDLE -> ACCESS -> RESP), with grant/done pulses back to the winning requester.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk_2,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         we,
    input  logic [NREQ*ADDR_W-1:0]  addr,
    input  logic [NREQ*DATA_W-1:0]  wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [DATA_W-1:0]       rdata,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0][ADDR_W-1:0] addr_v;
    logic [NREQ-1:0][DATA_W-1:0] wdata_v;

    assign addr_v  = addr;
    assign wdata_v = wdata;

    arb_state_t        state_q;
    logic [OW-1:0]     owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic              busy_q;

    logic [OW-1:0]     pick_idx;
    logic [OW-1:0]     cand;
    logic              pick_vld;

    // Scan starts just past the last owner, so the last winner has lowest priority.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = owner_q;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = OW'((int'(owner_q) + k) % NREQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= OW'(NREQ - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q <= ACCESS;
                        owner_q <= pick_idx;
                        we_q    <= we[pick_idx];
                        addr_q  <= addr_v[pick_idx];
                        wdata_q <= wdata_v[pick_idx];
                        gnt_q   <= NREQ'(1) << pick_idx;
                        busy_q  <= 1'b1;
                    end
                end
                ACCESS: begin
                    state_q <= RESP;
                    gnt_q   <= '0;
                    done_q  <= NREQ'(1) << owner_q;
                end
                RESP: begin
                    state_q <= IDLE;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Memory access happens at the edge that ends ACCESS, using the latched op.
    logic mem_we;
    logic mem_re;

    assign mem_we = (state_q == ACCESS) &&  we_q;
    assign mem_re = (state_q == ACCESS) && !we_q;

    mem_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .we      (mem_we),
        .re      (mem_re),
        .addr    (addr_q),
        .wdata   (wdata_q),
        .rdata   (rdata)
    );

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: op table plus hand sequences, done pulses checked via scoreboard.
module tb_mem_rr_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 2;
    localparam int DW   = 4;

    logic                 clk_2 = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      we;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [DW-1:0]        rdata;
    logic                 busy;
    logic                 owner;

    always #5 clk_2 = ~clk_2;

    mem_rr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .gnt     (gnt),
        .done    (done),
        .rdata   (rdata),
        .busy    (busy),
        .owner   (owner)
    );

    typedef struct {
        int           who;
        bit           w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        int            who;
        bit            rd;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sb_q[$];
    logic [DW-1:0] mem_m [4];
    vec_t          tbl [9];
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] oh(input int who);
        return 32'(1) << who;
    endfunction

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic set_req(input int who, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        we[who]           = w;
        addr[who*AW +: AW] = a;
        wdata[who*DW +: DW] = d;
    endtask

    // One isolated op: grant one cycle after the request edge, done one cycle later.
    task automatic do_op(input int who, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp);
        set_req(who, w, a, d);
        req      = '0;
        req[who] = 1'b1;
        sb_q.push_back('{who, !w, exp});
        if (w) mem_m[a] = d;
        step();
        check("gnt_lat", 32'(gnt), oh(who));
        check("busy_acc", 32'(busy), 32'd1);
        step();
        check("done_lat", 32'(done), oh(who));
        req = '0;
        step();
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    // Completion monitor: every done pulse must match the oldest outstanding op.
    always @(negedge clk_2) begin
        if (reset_n === 1'b1 && done !== '0) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got done=%b want none", done);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_who", 32'(done), oh(e.who));
                if (e.rd) check("sb_rdata", 32'(rdata), 32'(e.data));
            end
        end
        if (reset_n === 1'b1 && gnt !== '0) check("gnt_onehot", 32'($countones(gnt)), 32'd1);
    end

    initial begin
        tbl[0] = '{0, 1'b1, 2'd2, 4'hA, 4'h0};
        tbl[1] = '{0, 1'b0, 2'd2, 4'h0, 4'hA};
        tbl[2] = '{1, 1'b1, 2'd0, 4'h5, 4'h0};
        tbl[3] = '{1, 1'b0, 2'd0, 4'h0, 4'h5};
        tbl[4] = '{0, 1'b0, 2'd1, 4'h0, 4'h0};
        tbl[5] = '{1, 1'b1, 2'd3, 4'hF, 4'h0};
        tbl[6] = '{0, 1'b0, 2'd3, 4'h0, 4'hF};
        tbl[7] = '{0, 1'b1, 2'd2, 4'hC, 4'h0};
        tbl[8] = '{1, 1'b0, 2'd2, 4'h0, 4'hC};
        for (int i = 0; i < 4; i++) mem_m[i] = '0;

        reset_n = 1'b1;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        #2 reset_n = 1'b0;
        #2;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_owner", 32'(owner), 32'd1);
        step();
        step();
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++)
            do_op(tbl[i].who, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp);

        // Contention: last owner was 1, so both held gives 0,1,0,1.
        set_req(0, 1'b0, 2'd2, 4'h0);
        set_req(1, 1'b0, 2'd0, 4'h0);
        for (int k = 0; k < 4; k++)
            sb_q.push_back('{k % 2, 1'b1, (k % 2 == 0) ? mem_m[2] : mem_m[0]});
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            check("cont_gnt", 32'(gnt), oh(k % 2));
            check("cont_owner", 32'(owner), 32'(k % 2));
            step();
            if (k == 3) req = '0;
            step();
            check("cont_idle_busy", 32'(busy), 32'd0);
        end

        // Fairness: with owner 0, both requesting must serve 1 before 0.
        do_op(0, 1'b0, 2'd1, 4'h0, mem_m[1]);
        set_req(0, 1'b0, 2'd3, 4'h0);
        set_req(1, 1'b0, 2'd2, 4'h0);
        sb_q.push_back('{1, 1'b1, mem_m[2]});
        sb_q.push_back('{0, 1'b1, mem_m[3]});
        req = 2'b11;
        step();
        check("fair_gnt1", 32'(gnt), oh(1));
        check("fair_owner1", 32'(owner), 32'd1);
        step();
        step();
        step();
        check("fair_gnt0", 32'(gnt), oh(0));
        check("fair_owner0", 32'(owner), 32'd0);
        step();
        req = '0;
        step();

        // Late change: addr/wdata altered during ACCESS must not affect the op.
        set_req(0, 1'b1, 2'd1, 4'h9);
        req = 2'b01;
        sb_q.push_back('{0, 1'b0, 4'h0});
        mem_m[1] = 4'h9;
        step();
        set_req(0, 1'b1, 2'd3, 4'h6);
        step();
        req = '0;
        step();
        do_op(0, 1'b0, 2'd1, 4'h0, 4'h9);
        do_op(0, 1'b0, 2'd3, 4'h0, mem_m[3]);

        // Reset during ACCESS of a write: op dropped, no done, memory cleared.
        set_req(0, 1'b1, 2'd3, 4'h5);
        req = 2'b01;
        step();
        check("rst6_gnt_before", 32'(gnt), oh(0));
        #2 reset_n = 1'b0;
        #1;
        check("rst6_gnt", 32'(gnt), 32'd0);
        check("rst6_done", 32'(done), 32'd0);
        check("rst6_busy", 32'(busy), 32'd0);
        check("rst6_rdata", 32'(rdata), 32'd0);
        check("rst6_owner", 32'(owner), 32'd1);
        for (int i = 0; i < 4; i++) mem_m[i] = '0;
        step();
        step();
        req = '0;
        reset_n = 1'b1;
        step();
        check("rst6_no_done", 32'(done), 32'd0);
        for (int a = 0; a < 4; a++) do_op(0, 1'b0, AW'(a), 4'h0, 4'h0);

        step();
        check("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
